// File: rtl/ram_sp_param_pkg.sv
// Shared definitions for the single-port byte-enabled RAM:
// FSM state encoding and default geometry.
package ram_sp_param_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Count of byte lanes in a data word.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage for ram_sp_param: synchronous byte-enabled array with a registered
// read port. Deliberately has no reset so it maps onto plain RAM macros.
module ram_sp_array
  import ram_sp_param_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [DATA_W/8-1:0]       be,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  output logic [DATA_W-1:0]         rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = be_width(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write; disabled lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds the previous word when no read is issued.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ram_sp_param.sv
// Single-port RAM with byte enables, optional zero-fill sweep after reset,
// and write-priority arbitration that flags rejected or colliding requests.
module ram_sp_param
  import ram_sp_param_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_in,
  input  logic                re_in,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   d_in,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   d_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                err
);

  localparam int              BE_W       = be_width(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam state_e          RST_STATE  = (CLR_ON_RST != 0) ? CLEAR : IDLE;
  localparam logic            RST_BUSY   = (CLR_ON_RST != 0);

  state_e              state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                rd_valid_r;
  logic                err_r;
  logic                busy_r;
  logic                have_data_r;

  logic                mem_we_s;
  logic                mem_re_s;
  logic [BE_W-1:0]     mem_be_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   mem_rdata_s;

  // Port arbitration: sweep owns the array in CLEAR, writes beat reads in IDLE.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_be_s    = '0;
    mem_addr_s  = addr;
    mem_wdata_s = d_in;
    if (rst) begin
      case (state_r)
        CLEAR: begin
          mem_we_s    = 1'b1;
          mem_be_s    = '1;
          mem_addr_s  = cnt_r;
          mem_wdata_s = '0;
        end
        IDLE: begin
          if (wr_in) begin
            mem_we_s = 1'b1;
            mem_be_s = be;
          end else if (re_in) begin
            mem_re_s = 1'b1;
          end else begin
            mem_we_s = 1'b0;
            mem_re_s = 1'b0;
          end
        end
        default: begin
          mem_we_s = 1'b0;
          mem_re_s = 1'b0;
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
      mem_re_s = 1'b0;
    end
  end

  // Control FSM, sweep counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= RST_STATE;
      cnt_r       <= '0;
      busy_r      <= RST_BUSY;
      rd_valid_r  <= 1'b0;
      err_r       <= 1'b0;
      have_data_r <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          cnt_r      <= cnt_r + 1'b1;
          rd_valid_r <= 1'b0;
          err_r      <= wr_in | re_in;
          if (cnt_r == LAST_ADDR) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end
        end
        IDLE: begin
          rd_valid_r  <= mem_re_s;
          err_r       <= wr_in & re_in;
          have_data_r <= have_data_r | mem_re_s;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r    <= RST_STATE;
          cnt_r      <= '0;
          busy_r     <= RST_BUSY;
          rd_valid_r <= 1'b0;
          err_r      <= 1'b0;
        end
      endcase
    end
  end

  ram_sp_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .be    (mem_be_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .re    (mem_re_s),
    .rdata (mem_rdata_s)
  );

  // The array has no reset, so read data is masked until a read completes.
  assign d_out    = have_data_r ? mem_rdata_s : '0;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: sweep timing, byte enables, collisions,
// reset behaviour, 16-bit data and the no-sweep variant.
module tb_ram_sp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 8-bit data, sweep enabled
  logic       rst_a, a_wr, a_re, a_rd_valid, a_busy, a_err;
  logic [3:0] a_addr;
  logic [7:0] a_d, a_d_out;
  logic [0:0] a_be;
  // DUT B: 16-bit data
  logic        rst_b, b_wr, b_re, b_rd_valid, b_busy, b_err;
  logic [3:0]  b_addr;
  logic [15:0] b_d, b_d_out;
  logic [1:0]  b_be;
  // DUT C: no sweep
  logic       rst_c, c_wr, c_re, c_rd_valid, c_busy, c_err;
  logic [3:0] c_addr;
  logic [7:0] c_d, c_d_out;
  logic [0:0] c_be;

  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rst(rst_a), .wr_in(a_wr), .re_in(a_re), .addr(a_addr), .d_in(a_d),
    .be(a_be), .d_out(a_d_out), .rd_valid(a_rd_valid), .busy(a_busy), .err(a_err));

  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .CLR_ON_RST(1)) dut_b (
    .clk(clk), .rst(rst_b), .wr_in(b_wr), .re_in(b_re), .addr(b_addr), .d_in(b_d),
    .be(b_be), .d_out(b_d_out), .rd_valid(b_rd_valid), .busy(b_busy), .err(b_err));

  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .CLR_ON_RST(0)) dut_c (
    .clk(clk), .rst(rst_c), .wr_in(c_wr), .re_in(c_re), .addr(c_addr), .d_in(c_d),
    .be(c_be), .d_out(c_d_out), .rd_valid(c_rd_valid), .busy(c_busy), .err(c_err));

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] sb_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one read on DUT A; the expected word goes through the scoreboard.
  task automatic read_a(input logic [3:0] a, input logic [7:0] exp, input string tag);
    sb_q.push_back({8'h00, exp});
    a_re   = 1'b1;
    a_addr = a;
    tick();
    a_re = 1'b0;
    check1({tag, "_valid"}, a_rd_valid, 1'b1);
    check(tag, {8'h00, a_d_out}, sb_q.pop_front());
  endtask

  task automatic write_a(input logic [3:0] a, input logic [7:0] d, input logic be_bit);
    a_wr   = 1'b1;
    a_addr = a;
    a_d    = d;
    a_be   = be_bit;
    tick();
    a_wr = 1'b0;
  endtask

  // Count busy cycles from now until busy drops, bounded.
  task automatic count_busy(input int start, output int total, output logic err_seen);
    total    = start;
    err_seen = 1'b0;
    for (int i = 0; i < 40 && a_busy; i++) begin
      total++;
      if (a_err) err_seen = 1'b1;
      tick();
    end
  endtask

  int   nbusy;
  logic eseen;

  initial begin
    rst_a = 1'b0; a_wr = 1'b0; a_re = 1'b0; a_addr = 4'h0; a_d = 8'h00; a_be = 1'b0;
    rst_b = 1'b0; b_wr = 1'b0; b_re = 1'b0; b_addr = 4'h0; b_d = 16'h0000; b_be = 2'b00;
    rst_c = 1'b0; c_wr = 1'b0; c_re = 1'b0; c_addr = 4'h0; c_d = 8'h00; c_be = 1'b0;
    tick();
    tick();
    check("rst_dout", {8'h00, a_d_out}, 16'h0000);
    check1("rst_valid", a_rd_valid, 1'b0);
    check1("rst_err", a_err, 1'b0);
    check1("rst_busy", a_busy, 1'b1);
    check1("rst_busy_noclr", c_busy, 1'b0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    count_busy(0, nbusy, eseen);
    check("sweep_len", 16'(nbusy), 16'd16);
    check1("sweep_no_err", eseen, 1'b0);
    check1("b_busy_done", b_busy, 1'b0);
    for (int i = 0; i < 16; i++) read_a(4'(i), 8'h00, "init_zero");
    check1("reads_no_err", a_err, 1'b0);

    // Write then immediately read the same address
    write_a(4'hD, 8'h33, 1'b1);
    check1("wr_no_valid", a_rd_valid, 1'b0);
    read_a(4'hD, 8'h33, "raw_D");
    tick();
    check1("idle_valid", a_rd_valid, 1'b0);
    check("idle_hold", {8'h00, a_d_out}, 16'h0033);

    // Disabled byte lane must not change the word
    write_a(4'hD, 8'hFF, 1'b0);
    read_a(4'hD, 8'h33, "be_off");

    // Collision: write wins, read dropped, err next cycle
    a_wr = 1'b1; a_re = 1'b1; a_addr = 4'h9; a_d = 8'h3F; a_be = 1'b1;
    tick();
    a_wr = 1'b0; a_re = 1'b0;
    check1("coll_valid", a_rd_valid, 1'b0);
    check1("coll_err", a_err, 1'b1);
    check("coll_hold", {8'h00, a_d_out}, 16'h0033);
    tick();
    check1("coll_err_pulse", a_err, 1'b0);
    read_a(4'h9, 8'h3F, "coll_mem");

    // Reset aborts a read issued on the reset edge
    a_re = 1'b1; a_addr = 4'h9; rst_a = 1'b0;
    tick();
    a_re = 1'b0;
    check1("abort_valid", a_rd_valid, 1'b0);
    check("abort_dout", {8'h00, a_d_out}, 16'h0000);
    check1("abort_busy", a_busy, 1'b1);
    tick();
    rst_a = 1'b1;

    // Write request at sweep cycle 5 is ignored and flagged
    for (int i = 0; i < 5; i++) tick();
    write_a(4'h2, 8'hAA, 1'b1);
    check1("sweep_wr_err", a_err, 1'b1);
    check1("sweep_wr_busy", a_busy, 1'b1);
    count_busy(6, nbusy, eseen);
    check("sweep_len2", 16'(nbusy), 16'd16);
    read_a(4'h2, 8'h00, "sweep_wr_ign");
    read_a(4'h9, 8'h00, "swept_9");
    read_a(4'hD, 8'h00, "swept_D");

    // Reset at sweep cycle 8 restarts the full sweep
    write_a(4'hF, 8'h55, 1'b1);
    read_a(4'hF, 8'h55, "pre_rst_F");
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rst_a = 1'b0;
    tick();
    check1("midsweep_rst_busy", a_busy, 1'b1);
    rst_a = 1'b1;
    count_busy(0, nbusy, eseen);
    check("restart_len", 16'(nbusy), 16'd16);
    check1("restart_no_err", eseen, 1'b0);
    for (int i = 0; i < 16; i++) read_a(4'(i), 8'h00, "restart_zero");

    // 16-bit data with partial byte enable
    b_wr = 1'b1; b_addr = 4'h2; b_d = 16'hAAAA; b_be = 2'b11;
    tick();
    b_d = 16'h1234; b_be = 2'b01;
    tick();
    b_wr = 1'b0;
    sb_q.push_back(16'hAA34);
    b_re = 1'b1;
    tick();
    b_re = 1'b0;
    check1("w16_valid", b_rd_valid, 1'b1);
    check("w16_merge", b_d_out, sb_q.pop_front());
    check1("w16_err", b_err, 1'b0);

    // No-sweep variant: reset leaves memory contents intact
    c_wr = 1'b1; c_addr = 4'h3; c_d = 8'h77; c_be = 1'b1;
    tick();
    c_wr = 1'b0;
    rst_c = 1'b0;
    tick();
    check1("noclr_busy", c_busy, 1'b0);
    check("noclr_rst_dout", {8'h00, c_d_out}, 16'h0000);
    rst_c = 1'b1;
    sb_q.push_back(16'h0077);
    c_re = 1'b1; c_addr = 4'h3;
    tick();
    c_re = 1'b0;
    check1("noclr_valid", c_rd_valid, 1'b1);
    check("noclr_keep", {8'h00, c_d_out}, sb_q.pop_front());
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter CLR_ON_RST, default 1, 1 = zero-fill sweep after reset, 0 = no sweep.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-006 wr_in  in  1  write request, one word per cycle while high.
REQ-007 re_in  in  1  read request, one word per cycle while high.
REQ-008 addr  in  ADDR_W  word address for the read or write.
REQ-009 d_in  in  DATA_W  write data.
REQ-010 be  in  DATA_W/8  byte enables; bit i gates d_in[8i+7:8i].
REQ-011 d_out  out  DATA_W  registered read data.
REQ-012 rd_valid  out  1  one-cycle pulse marking d_out as new.
REQ-013 busy  out  1  high while the clear sweep runs.
REQ-014 err  out  1  one-cycle pulse on a rejected or colliding request.

Function
REQ-015 FSM SHALL have two states: CLEAR (sweep running) and IDLE (accepting requests).
REQ-016 Write: in IDLE with wr_in=1, each byte i with be[i]=1 SHALL take the d_in byte at addr on that edge; bytes with be[i]=0 keep their value.
REQ-017 Read: in IDLE with re_in=1 and wr_in=0, d_out SHALL equal mem[addr] one cycle later, with rd_valid=1 in that same cycle.
REQ-018 d_out SHALL hold its last value when no read completes; rd_valid SHALL be 0 in those cycles.
REQ-019 Simultaneous wr_in=1 and re_in=1 in IDLE: the write SHALL complete, the read SHALL be dropped (rd_valid stays 0), and err SHALL pulse next cycle.
REQ-020 Read of an address written the previous cycle SHALL return the new data (no stale read).
REQ-021 CLEAR state: a sweep counter SHALL write all-zero data to addresses 0..2**ADDR_W-1, one per cycle, with busy=1.
REQ-022 After writing address 2**ADDR_W-1, the sweep SHALL go to IDLE and busy SHALL drop on the following edge; the counter wraps to 0.
REQ-023 Any wr_in or re_in during CLEAR SHALL be ignored (no write, no rd_valid) and SHALL pulse err the next cycle.
REQ-024 Sweep duration SHALL be exactly 2**ADDR_W cycles from the first cycle after rst deasserts.
REQ-025 With CLR_ON_RST=0, the block SHALL enter IDLE directly; memory contents are then undefined until written.

Reset
REQ-026 While rst=0 at an edge, outputs SHALL be d_out=0, rd_valid=0, err=0, busy=CLR_ON_RST, with state=CLEAR (or IDLE if CLR_ON_RST=0) and sweep counter=0.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-028 Reset asserted in IDLE SHALL abort any in-flight read (no rd_valid), and SHALL start a new sweep if CLR_ON_RST=1.
REQ-029 Reset SHALL not itself clear the memory array; only the sweep clears it.

Structure
REQ-030 A shared package SHALL hold the state encoding (CLEAR, IDLE) and the default parameter constants DATA_W_DEF=8 and ADDR_W_DEF=4.
REQ-031 Storage SHALL be one sub-module, ram_sp_array: a synchronous byte-enabled array with a registered read and no reset. The FSM, sweep counter and arbitration stay in ram_sp_param.

Verification
REQ-032 Reset (DATA_W=8, ADDR_W=4), release -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 8'h00; no err pulses.
REQ-033 Write 8'h33 to addr 4'hD with be=1, next cycle read 4'hD -> d_out=8'h33 with rd_valid=1 exactly one cycle after the read request.
REQ-034 DATA_W=16: write 16'hAAAA to addr 2, then write 16'h1234 to addr 2 with be=2'b01, read addr 2 -> 16'hAA34.
REQ-035 wr_in=1 and re_in=1 together (addr 9, d_in 8'h3F) -> mem[9]=8'h3F, no rd_valid, err=1 for one cycle.
REQ-036 Write request at sweep cycle 5 -> ignored and err pulses; after busy drops, the target address reads 8'h00.
REQ-037 Assert rst at sweep cycle 8, release -> sweep restarts at address 0, busy stays high 16 more cycles, all addresses read 0.
